// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver: majority-vote bit decisions, false-start
// rejection, parity/framing error flags, saturating frame counter and sticky end flag.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int END_COUNT   = 1024,
  localparam int CW = (END_COUNT > 0) ? $clog2(END_COUNT + 1) : 1
) (
  input  logic                 BRclk16,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic                 UART_TX,
  output logic [DATA_BITS-1:0] RX_data,
  output logic                 UART_read_en,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [CW-1:0]        rx_count,
  output logic                 UART_end_flag,
  output logic [2:0]           rx_state
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE * (DATA_BITS + 4));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [TW-1:0]        tick_cnt, bit_base, phase;
  logic [3:0]           bit_cnt;
  logic                 s_early, s_mid;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend, ferr_pend;
  logic                 decide, maj, last_data, last_stop;
  logic                 frame_done, cur_ferr, par_bad;

  // Output handshake: UART_read_en is a one-cycle valid with no ready; RX_data,
  // parity_err and frame_err are valid in that cycle and hold until the next strobe.
  assign UART_TX  = 1'b1;
  assign rx_state = state;

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    decide     = 1'b0;
    phase      = tick_cnt - bit_base;
    maj        = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);
    last_data  = (bit_cnt == 4'(DATA_BITS - 1));
    last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
    cur_ferr   = (bit_cnt == 4'd0) ? ~maj : ferr_pend;
    par_bad    = (PARITY_MODE == 1) ? (maj != ^shreg) : (maj == ^shreg);
    if (state inside {S_START, S_DATA, S_PARITY, S_STOP})
      decide = (phase == TW'(H + 1));
    case (state)
      S_IDLE:   if (!rxs) state_n = S_START;
      S_START:  if (decide) state_n = maj ? S_IDLE : S_DATA;
      S_DATA:   if (decide && last_data) state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (decide) state_n = S_STOP;
      S_STOP: begin
        if (decide && last_stop) begin
          frame_done = 1'b1;
          state_n    = cur_ferr ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK:  if (rxs) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge BRclk16) begin
    if (reset) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      state         <= S_IDLE;
      tick_cnt      <= '0;
      bit_base      <= '0;
      bit_cnt       <= '0;
      s_early       <= 1'b1;
      s_mid         <= 1'b1;
      shreg         <= '0;
      par_pend      <= 1'b0;
      ferr_pend     <= 1'b0;
      RX_data       <= '0;
      UART_read_en  <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      rx_count      <= '0;
      UART_end_flag <= 1'b0;
    end else begin
      rx_meta      <= UART_RX;
      rxs          <= rx_meta;
      state        <= state_n;
      UART_read_en <= frame_done;
      // The idle cycle that sees rxs low is tick 0, so the first START cycle is tick 1.
      if (state == S_IDLE) begin
        tick_cnt  <= TW'(1);
        bit_base  <= '0;
        bit_cnt   <= '0;
        par_pend  <= 1'b0;
        ferr_pend <= 1'b0;
      end else if (state != S_BREAK) begin
        tick_cnt <= tick_cnt + TW'(1);
        if (phase == TW'(H - 1)) s_early <= rxs;
        if (phase == TW'(H))     s_mid   <= rxs;
        if (decide) begin
          bit_base <= bit_base + TW'(OVERSAMPLE);
          case (state)
            S_DATA: begin
              shreg   <= {maj, shreg[DATA_BITS-1:1]};
              bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
            end
            S_PARITY: par_pend <= par_bad;
            S_STOP: begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd0) ferr_pend <= ~maj;
            end
            default: ;
          endcase
        end
      end
      if (frame_done) begin
        RX_data    <= shreg;
        parity_err <= par_pend;
        frame_err  <= cur_ferr;
        if (END_COUNT == 0 || rx_count != CW'(END_COUNT))
          rx_count <= rx_count + CW'(1);
      end
      if (END_COUNT != 0 && rx_count == CW'(END_COUNT))
        UART_end_flag <= 1'b1;
    end
  end

endmodule
